// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch, load/store) arbiter in front of a single-port sync RAM.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise load/store has fixed priority.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  state_t state_q, state_d;
  logic owner_ls_q, owner_ls_d;
  logic if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic [AW-1:0] ram_address_q, ram_address_d;
  logic [DW-1:0] ram_data_q, ram_data_d;
  logic ram_wren_q, ram_wren_d;
  logic pick_ls;
`ifdef MEM_ARB_RR_EN
  logic last_ls_q, last_ls_d;
  assign pick_ls = ls_req & (~if_req | ~last_ls_q);
`else
  assign pick_ls = ls_req;
`endif
  always_comb begin
    state_d       = state_q;
    owner_ls_d    = owner_ls_q;
    if_gnt_d      = 1'b0;
    ls_gnt_d      = 1'b0;
    if_rvalid_d   = 1'b0;
    ls_rvalid_d   = 1'b0;
    if_rdata_d    = if_rdata_q;
    ls_rdata_d    = ls_rdata_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_ls_d     = last_ls_q;
`endif
    case (state_q)
      IDLE: if (if_req | ls_req) begin
        state_d       = ACCESS;
        owner_ls_d    = pick_ls;
        ram_address_d = pick_ls ? ls_addr : if_addr;
        ram_data_d    = pick_ls ? ls_wdata : ram_data_q;
        ram_wren_d    = pick_ls & ls_we;
        if_gnt_d      = ~pick_ls;
        ls_gnt_d      = pick_ls;
`ifdef MEM_ARB_RR_EN
        last_ls_d     = pick_ls;
`endif
      end
      ACCESS: state_d = ram_wren_q ? IDLE : WAIT;
      WAIT: begin
        state_d     = IDLE;
        if_rvalid_d = ~owner_ls_q;
        ls_rvalid_d = owner_ls_q;
        if_rdata_d  = owner_ls_q ? if_rdata_q : ram_q;
        ls_rdata_d  = owner_ls_q ? ram_q : ls_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_ls_q    <= 1'b0;
      if_gnt_q      <= 1'b0;
      ls_gnt_q      <= 1'b0;
      if_rvalid_q   <= 1'b0;
      ls_rvalid_q   <= 1'b0;
      if_rdata_q    <= '0;
      ls_rdata_q    <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_ls_q     <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      owner_ls_q    <= owner_ls_d;
      if_gnt_q      <= if_gnt_d;
      ls_gnt_q      <= ls_gnt_d;
      if_rvalid_q   <= if_rvalid_d;
      ls_rvalid_q   <= ls_rvalid_d;
      if_rdata_q    <= if_rdata_d;
      ls_rdata_q    <= ls_rdata_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
`ifdef MEM_ARB_RR_EN
      last_ls_q     <= last_ls_d;
`endif
    end
  end
  assign if_gnt      = if_gnt_q;
  assign ls_gnt      = ls_gnt_q;
  assign if_rvalid   = if_rvalid_q;
  assign ls_rvalid   = ls_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural sync RAM.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [7:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_wren, busy;
  logic [7:0] if_rdata, ls_rdata, ram_address, ram_data;
  logic [7:0] ram_q = '0;
  logic [7:0] mem [0:255];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy)
  );
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] seq;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 8'hA5;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_gnt", {if_gnt, ls_gnt}, 0);
    check("rst_rvalid", {if_rvalid, ls_rvalid}, 0);
    check("rst_ram", {ram_address, ram_data, 7'd0, ram_wren}, 0);
    check("rst_rdata", {if_rdata, ls_rdata}, 0);
    rst_n = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 8'h10;
    tick();
    check("f_gnt", {if_gnt, ls_gnt}, 2'b10);
    check("f_busy", busy, 1);
    check("f_addr", ram_address, 8'h10);
    check("f_wren", ram_wren, 0);
    if_req = 1'b0;
    tick();
    check("f_gnt_off", if_gnt, 0);
    check("f_rv_early", if_rvalid, 0);
    tick();
    check("f_rvalid", {if_rvalid, ls_rvalid}, 2'b10);
    check("f_rdata", if_rdata, 8'hA5);
    check("f_ls_quiet", {ls_gnt, ls_rdata}, 0);
    tick();
    check("f_rv_pulse", if_rvalid, 0);
    check("f_idle", busy, 0);
    check("f_hold", if_rdata, 8'hA5);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h20; ls_wdata = 8'h5C;
    tick();
    check("s_gnt", {if_gnt, ls_gnt}, 2'b01);
    check("s_ram", {ram_address, ram_data, 7'd0, ram_wren}, {8'h20, 8'h5C, 8'h01});
    ls_req = 1'b0;
    tick();
    check("s_wren_off", ram_wren, 0);
    check("s_idle", busy, 0);
    check("s_no_rv", ls_rvalid, 0);
    check("s_mem", mem[8'h20], 8'h5C);
    tick();
    check("s_no_rv2", ls_rvalid, 0);
    ls_req = 1'b1; ls_we = 1'b0;
    tick();
    check("l_gnt", ls_gnt, 1);
    check("l_wren", ram_wren, 0);
    ls_req = 1'b0;
    tick();
    tick();
    check("l_rvalid", {if_rvalid, ls_rvalid}, 2'b01);
    check("l_rdata", ls_rdata, 8'h5C);
    check("l_if_hold", if_rdata, 8'hA5);
    tick();
    if_req = 1'b1; if_addr = 8'h10; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h20;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(if_gnt | ls_gnt) && n < 10) begin
        tick();
        n++;
      end
      check("c_timeout", n < 10, 1);
      seq[g] = ls_gnt;
      tick();
    end
`ifdef MEM_ARB_RR_EN
    check("c_order", seq, 4'b1010);
`else
    check("c_order", seq, 4'b1111);
`endif
    if_req = 1'b0; ls_req = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    check("c_drain", busy, 0);
    tick();
    if_req = 1'b1; if_addr = 8'h10;
    tick();
    check("r_gnt", if_gnt, 1);
    if_req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("r_busy", busy, 0);
    check("r_quiet", {if_gnt, ls_gnt, if_rvalid, ls_rvalid}, 0);
    check("r_rdata", if_rdata, 0);
    rst_n = 1'b1;
    tick();
    check("r_no_rv", if_rvalid, 0);
    if_req = 1'b1; if_addr = 8'h20;
    tick();
    check("r2_gnt", if_gnt, 1);
    if_req = 1'b0;
    tick();
    tick();
    check("r2_rvalid", if_rvalid, 1);
    check("r2_rdata", if_rdata, 8'h5C);
    tick();
    if_req = 1'b1; if_addr = 8'h10;
    tick();
    check("p_fgnt", if_gnt, 1);
    if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h30; ls_wdata = 8'h77;
    tick();
    ls_req = 1'b0;
    check("p_gnt1", ls_gnt, 0);
    check("p_wren1", ram_wren, 0);
    tick();
    check("p_gnt2", ls_gnt, 0);
    check("p_rv", if_rvalid, 1);
    tick();
    check("p_gnt3", {ls_gnt, ram_wren}, 0);
    check("p_idle", busy, 0);
    tick();
    check("p_gnt4", {ls_gnt, ram_wren, busy}, 0);
    check("p_mem", mem[8'h30], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
